// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver / hex display.
//   rx_state_t : receiver FSM states
//   MID_TICK   : oversample tick index that lands on the middle of a bit
//   SEG_TABLE  : seven-segment glyphs for hex digits 0..F, bit 0 = a ... bit 6 = g
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int MID_TICK = 7;

  // Packed so that SEG_TABLE[n] is the glyph for nibble n (index 15 is leftmost).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/uart_rx_display_hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to seven-segment glyph.
//   nib : 4-bit value to display
//   seg : segments, seg[0]=a ... seg[6]=g, active-high
module hex_to_7seg
  import uart_rx_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/uart_rx_display.sv
// uart_rx_display: 16x-oversampled UART receiver (8 data bits, LSB first,
// optional even parity, 1 stop bit) showing the last good byte as two hex
// digits on a multiplexed seven-segment display.
//
// Build option: UART_RX_PARITY_EN
//   defined   -> frame is start + 8 data + even parity + stop, parity checked
//   undefined -> frame is 8N1, no parity bit, only framing errors reported
//
// Ports:
//   CLK   : system clock, rising edge
//   RST   : asynchronous reset, active-low
//   RXD   : serial line, idles high (synchronized internally)
//   Error : high when the last completed frame had a parity or framing error
//   AN    : registered segment drive, AN[0]=a ... AN[6]=g, active-high
//   CA    : digit select, 0 = low nibble, 1 = high nibble
//
// FSM states:
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge
//   START  | timing to middle of the start bit, rejecting glitches
//   DATA   | sampling 8 data bits at mid-bit
//   PARITY | sampling the parity bit (parity builds only)
//   STOP   | sampling the stop bit, then closing the frame
//
// The divide ratio CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2.
module uart_rx_display
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int REFRESH_HZ = 1_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic       Error,
  output logic [6:0] AN,
  output logic       CA
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int REF_DIV  = CLK_FREQ / (2 * REFRESH_HZ);
  localparam int TDW      = $clog2(TICK_DIV);
  localparam int RDW      = $clog2(REF_DIV);
  localparam int SW       = $clog2(OVERSAMPLE);

  localparam logic [TDW-1:0] TICK_LOAD = TDW'(TICK_DIV - 1);
  localparam logic [RDW-1:0] REF_LOAD  = RDW'(REF_DIV - 1);
  localparam logic [SW-1:0]  MID       = SW'(MID_TICK);
  localparam logic [SW-1:0]  LAST      = SW'(OVERSAMPLE - 1);

  logic            rxd_meta, rxd_s, rxd_prev;
  logic            rxd_fall;
  logic [TDW-1:0]  div_cnt;
  logic            tick;
  logic            start_edge;

  rx_state_t       state, state_nxt;
  logic [SW-1:0]   s_cnt, s_cnt_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      disp_byte, byte_nxt;
  logic            err_nxt;
  logic            perr, ferr;
`ifdef UART_RX_PARITY_EN
  logic            par_bit, par_nxt;
`endif

  logic [RDW-1:0]  ref_cnt;
  logic [3:0]      nib;
  logic [6:0]      seg;

  // Line synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign rxd_fall = rxd_prev & ~rxd_s;

  // Oversample tick divider; restarted on the start edge so the mid-bit
  // sample points are aligned to the edge rather than a free-running phase.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_cnt <= TICK_LOAD;
    end else if (start_edge || div_cnt == '0) begin
      div_cnt <= TICK_LOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  assign tick = (div_cnt == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      s_cnt     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      disp_byte <= '0;
      Error     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      s_cnt     <= s_cnt_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      disp_byte <= byte_nxt;
      Error     <= err_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    s_cnt_nxt  = s_cnt;
    bit_nxt    = bit_idx;
    shift_nxt  = shift;
    byte_nxt   = disp_byte;
    err_nxt    = Error;
    start_edge = 1'b0;
    perr       = 1'b0;
    ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt    = par_bit;
`endif
    unique case (state)
      IDLE: begin
        if (rxd_fall) begin
          start_edge = 1'b1;
          s_cnt_nxt  = '0;
          state_nxt  = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt == MID) begin
            s_cnt_nxt = '0;
            bit_nxt   = '0;
            state_nxt = rxd_s ? IDLE : DATA;
          end else begin
            s_cnt_nxt = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt == LAST) begin
            s_cnt_nxt = '0;
            shift_nxt = {rxd_s, shift[7:1]};
            bit_nxt   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            s_cnt_nxt = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_cnt == LAST) begin
            s_cnt_nxt = '0;
            par_nxt   = rxd_s;
            state_nxt = STOP;
          end else begin
            s_cnt_nxt = s_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_cnt == LAST) begin
            s_cnt_nxt = '0;
            ferr      = ~rxd_s;
`ifdef UART_RX_PARITY_EN
            perr      = (^shift) ^ par_bit;
`endif
            err_nxt   = perr | ferr;
            if (!(perr | ferr)) begin
              byte_nxt = shift;
            end
            // Return without waiting out the stop bit so a back-to-back
            // start edge is not missed.
            state_nxt = IDLE;
          end else begin
            s_cnt_nxt = s_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit multiplexing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ref_cnt <= REF_LOAD;
      CA      <= 1'b0;
    end else if (ref_cnt == '0) begin
      ref_cnt <= REF_LOAD;
      CA      <= ~CA;
    end else begin
      ref_cnt <= ref_cnt - 1'b1;
    end
  end

  assign nib = CA ? disp_byte[7:4] : disp_byte[3:0];

  hex_to_7seg u_seg (
    .nib (nib),
    .seg (seg)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      AN <= 7'h3F;
    end else begin
      AN <= seg;
    end
  end

endmodule

// File: tb/tb_uart_rx_display.sv
// tb_uart_rx_display: directed bench for uart_rx_display at 1.536 MHz,
// 9600 baud (160 clocks per bit), 1 kHz refresh (CA toggles every 768 clocks).
// Follows UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_display;

  localparam int BIT_CLKS = 160;
  localparam int REF_CLKS = 768;
  localparam int WAIT_MAX = 5000;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RXD = 1'b1;
  logic       Error;
  logic [6:0] AN;
  logic       CA;

  int n_total = 0;
  int n_bad   = 0;

  logic [6:0] exp_lo, exp_hi;
  logic       exp_err;

  uart_rx_display #(
    .CLK_FREQ   (1_536_000),
    .BAUD_RATE  (9_600),
    .OVERSAMPLE (16),
    .REFRESH_HZ (1_000)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .RXD   (RXD),
    .Error (Error),
    .AN    (AN),
    .CA    (CA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for CA to change; n = negedges waited.
  task automatic wait_ca_edge(output int n);
    logic v;
    v = CA;
    n = 0;
    while (CA === v && n < WAIT_MAX) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic check_disp(input string tag, input logic [6:0] lo, input logic [6:0] hi);
    int n;
    wait_ca_edge(n);
    chk({tag, "_tmo0"}, 16'(n >= WAIT_MAX), 16'd0);
    if (CA !== 1'b0) begin
      wait_ca_edge(n);
      chk({tag, "_tmo1"}, 16'(n >= WAIT_MAX), 16'd0);
    end
    repeat (2) @(negedge CLK);
    chk({tag, "_lo"}, 16'(AN), 16'(lo));
    wait_ca_edge(n);
    chk({tag, "_tmo2"}, 16'(n >= WAIT_MAX), 16'd0);
    repeat (2) @(negedge CLK);
    chk({tag, "_hi"}, 16'(AN), 16'(hi));
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    RXD = 1'b0;
    repeat (BIT_CLKS) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      repeat (BIT_CLKS) @(negedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    RXD = par;
    repeat (BIT_CLKS) @(negedge CLK);
`endif
    RXD = stp;
    repeat (BIT_CLKS) @(negedge CLK);
    RXD = 1'b1;
  endtask

  initial begin
    int n;

    // Reset and idle.
    RST = 1'b0;
    RXD = 1'b1;
    repeat (10) @(negedge CLK);
    chk("rst_err", 16'(Error), 16'd0);
    chk("rst_an", 16'(AN), 16'h3F);
    chk("rst_ca", 16'(CA), 16'd0);
    RST = 1'b1;
    wait_ca_edge(n);
    chk("ca_first_tmo", 16'(n >= WAIT_MAX), 16'd0);
    wait_ca_edge(n);
    chk("ca_period", 16'(n), 16'(REF_CLKS));
    check_disp("idle", 7'h3F, 7'h3F);

    // Good frame 0x41: digits "1" and "4".
    send_frame(8'h41, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    chk("good41_err", 16'(Error), 16'd0);
    check_disp("good41", 7'h06, 7'h66);

    // 0x4F sent with parity 0: bad parity when parity is checked, a plain
    // good byte in the 8N1 build.
`ifdef UART_RX_PARITY_EN
    exp_err = 1'b1; exp_lo = 7'h06; exp_hi = 7'h66;
`else
    exp_err = 1'b0; exp_lo = 7'h71; exp_hi = 7'h66;
`endif
    send_frame(8'h4F, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    chk("par4f_err", 16'(Error), 16'(exp_err));
    check_disp("par4f", exp_lo, exp_hi);

    // Framing error: 0x55, correct parity, stop bit 0.
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (20) @(negedge CLK);
    chk("frm55_err", 16'(Error), 16'd1);
    check_disp("frm55", exp_lo, exp_hi);

    // False start: 40-clock low pulse must change nothing.
    RXD = 1'b0;
    repeat (40) @(negedge CLK);
    RXD = 1'b1;
    repeat (300) @(negedge CLK);
    chk("glitch_err", 16'(Error), 16'd1);
    check_disp("glitch", exp_lo, exp_hi);

    // Good frame after the errors: 0x3C -> "C" low, "3" high.
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    chk("good3c_err", 16'(Error), 16'd0);
    check_disp("good3c", 7'h39, 7'h4F);

    // Back-to-back 0xA5 then 0x96 (both four ones, parity 0).
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("b2b_a5_err", 16'(Error), 16'd0);
    send_frame(8'h96, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    chk("b2b_96_err", 16'(Error), 16'd0);
    check_disp("b2b_96", 7'h7D, 7'h6F);

    // Set Error, then reset in the middle of data bit 4 of another frame.
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (20) @(negedge CLK);
    chk("pre_rst_err", 16'(Error), 16'd1);
    fork
      send_frame(8'hE7, 1'b0, 1'b1);
      begin
        repeat (BIT_CLKS * 5 + 80) @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        chk("midrst_err", 16'(Error), 16'd0);
        chk("midrst_an", 16'(AN), 16'h3F);
        chk("midrst_ca", 16'(CA), 16'd0);
      end
    join
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    repeat (320) @(negedge CLK);
    chk("post_rst_err", 16'(Error), 16'd0);
    check_disp("post_rst", 7'h3F, 7'h3F);

    send_frame(8'h41, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    chk("again41_err", 16'(Error), 16'd0);
    check_disp("again41", 7'h06, 7'h66);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
